// File: rtl/mips_run_controller.sv
// -----------------------------------------------------------------------------
// mips_run_controller
//
// Sequences a single-cycle mips_core. Owns the PC register that feeds the
// core's pcIn and, after a programmable settle window, commits the core's
// pcOut back into it. A run/step/halt FSM decides when the next instruction
// may commit and records why execution stopped.
//
// Parameters
//   ADDR_W        PC / result width
//   RESET_PC      pcIn value after reset
//   SETTLE_CYCLES idle cycles before each commit (0 behaves as 1)
//   CNT_W         width of stepCount and maxSteps
//
// Ports
//   clock, reset_n           clock (rising edge), async active-low reset
//   start                    pulse: begin a run from current pcIn (IDLE/HALT)
//   stop                     pulse: halt once the in-flight instruction commits
//   stepMode                 1 = wait for stepReq between instructions
//   stepReq                  pulse: execute one instruction while waiting
//   maxSteps                 halt after this many commits, 0 = unlimited
//   pcOut, result            next PC and result bus from the core
//   pcIn                     registered PC to the core
//   coreEn                   high only in the commit cycle (core writes)
//   resultLatched            result captured at the last commit
//   stepCount                commits since last start, saturating
//   running, halted          state decode
//   haltCause                000 none, 001 stop, 010 maxSteps,
//                            011 self-loop, 100 breakpoint
//
// Optional feature: define MIPS_RUN_BREAKPOINT_EN to add bpValid/bpAddr
// inputs; a commit whose pcOut equals bpAddr halts with cause 100 before
// the instruction at bpAddr executes.
// -----------------------------------------------------------------------------
module mips_run_controller #(
    parameter int unsigned       ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter int unsigned       SETTLE_CYCLES = 2,
    parameter int unsigned       CNT_W         = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              stepMode,
    input  logic              stepReq,
    input  logic [CNT_W-1:0]  maxSteps,
    input  logic [ADDR_W-1:0] pcOut,
    input  logic [ADDR_W-1:0] result,
`ifdef MIPS_RUN_BREAKPOINT_EN
    input  logic              bpValid,
    input  logic [ADDR_W-1:0] bpAddr,
`endif
    output logic [ADDR_W-1:0] pcIn,
    output logic              coreEn,
    output logic [ADDR_W-1:0] resultLatched,
    output logic [CNT_W-1:0]  stepCount,
    output logic              running,
    output logic              halted,
    output logic [2:0]        haltCause
);

    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SCNT_W     = $clog2(SETTLE_EFF + 1);
    // Counter counts down to zero, so SETTLE lasts exactly SETTLE_EFF cycles.
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COMMIT,
        S_WAIT,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'b000,
        CAUSE_STOP  = 3'b001,
        CAUSE_MAX   = 3'b010,
        CAUSE_LOOP  = 3'b011,
        CAUSE_BREAK = 3'b100
    } cause_t;

    state_t            state;
    logic [SCNT_W-1:0] settle_cnt;
    logic              stop_pending;
    logic              step_mode_l;
    logic [CNT_W-1:0]  max_steps_l;
    logic [CNT_W-1:0]  step_inc;
    logic [CNT_W-1:0]  step_sat;
    logic              bp_hit;

    assign step_inc = stepCount + CNT_W'(1);
    assign step_sat = (&stepCount) ? stepCount : step_inc;

`ifdef MIPS_RUN_BREAKPOINT_EN
    assign bp_hit = bpValid && (pcOut == bpAddr);
`else
    assign bp_hit = 1'b0;
`endif

    assign coreEn  = (state == S_COMMIT);
    assign running = (state == S_SETTLE) || (state == S_COMMIT) || (state == S_WAIT);
    assign halted  = (state == S_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pcIn          <= RESET_PC;
            resultLatched <= '0;
            stepCount     <= '0;
            haltCause     <= CAUSE_NONE;
            stop_pending  <= 1'b0;
            settle_cnt    <= '0;
            step_mode_l   <= 1'b0;
            max_steps_l   <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state        <= S_SETTLE;
                        settle_cnt   <= SETTLE_LOAD;
                        stepCount    <= '0;
                        haltCause    <= CAUSE_NONE;
                        step_mode_l  <= stepMode;
                        max_steps_l  <= maxSteps;
                        stop_pending <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (stop) stop_pending <= 1'b1;
                    if (settle_cnt == '0) state <= S_COMMIT;
                    else                  settle_cnt <= settle_cnt - SCNT_W'(1);
                end

                S_COMMIT: begin
                    // The commit itself always happens; stop only picks the next state.
                    pcIn          <= pcOut;
                    resultLatched <= result;
                    stepCount     <= step_sat;
                    stop_pending  <= 1'b0;
                    if (stop_pending || stop) begin
                        state     <= S_HALT;
                        haltCause <= CAUSE_STOP;
                    end else if (bp_hit) begin
                        state     <= S_HALT;
                        haltCause <= CAUSE_BREAK;
                    end else if ((max_steps_l != '0) && (step_inc == max_steps_l)) begin
                        state     <= S_HALT;
                        haltCause <= CAUSE_MAX;
                    end else if (pcOut == pcIn) begin
                        state     <= S_HALT;
                        haltCause <= CAUSE_LOOP;
                    end else if (step_mode_l) begin
                        state <= S_WAIT;
                    end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                S_WAIT: begin
                    if (stop) begin
                        state     <= S_HALT;
                        haltCause <= CAUSE_STOP;
                    end else if (stepReq) begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
